// File: rtl/pcpi_bridge_pkg.sv
// Shared types and default constants for the PCPI serial bridge.
// Holds the bridge FSM state enum and an index-width helper.
package pcpi_bridge_pkg;

    localparam int DEF_SEG_W   = 4;
    localparam int DEF_INSN_W  = 32;
    localparam int DEF_RD_W    = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Index width that stays legal when there is only one segment.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcpi_seg_slicer.sv
// W-bit register with indexed SEG_W slice write, full parallel load
// and indexed SEG_W slice read.
// Ports: clk, rst_n (async low), i_wr_en/i_wr_idx/i_wr_seg slice write,
//        i_ld_en/i_ld_val full load (wins over slice write),
//        i_rd_idx/o_rd_seg slice read, o_q whole register.
module pcpi_seg_slicer #(
    parameter int W     = 32,
    parameter int SEG_W = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [SEG_W-1:0] i_wr_seg,
    input  logic             i_ld_en,
    input  logic [W-1:0]     i_ld_val,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [SEG_W-1:0] o_rd_seg,
    output logic [W-1:0]     o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_ld_en) begin
            r_q <= i_ld_val;
        end else if (i_wr_en) begin
            r_q[i_wr_idx*SEG_W +: SEG_W] <= i_wr_seg;
        end
    end

    assign o_rd_seg = r_q[i_rd_idx*SEG_W +: SEG_W];
    assign o_q      = r_q;

endmodule

// File: rtl/pcpi_serial_bridge.sv
// Serial host to PCPI bridge: loads an instruction SEG_W bits at a time,
// issues it on PCPI, then streams the result back SEG_W bits at a time.
// Ports: clk, rst_n (async low); seg_in/seg_valid/seg_ack host load;
//        pcpi_valid/pcpi_insn/pcpi_ready/pcpi_wr/pcpi_wait/pcpi_rd PCPI;
//        rd_seg_out/rd_seg_valid/rd_seg_ack result readback; busy, err.
// Option: define PCPI_TIMEOUT_EN to abort ISSUE after TIMEOUT idle cycles.
module pcpi_serial_bridge
    import pcpi_bridge_pkg::*;
#(
    parameter int SEG_W   = DEF_SEG_W,
    parameter int INSN_W  = DEF_INSN_W,
    parameter int RD_W    = DEF_RD_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEG_W-1:0]  seg_in,
    input  logic              seg_valid,
    output logic              seg_ack,
    output logic              pcpi_valid,
    output logic [INSN_W-1:0] pcpi_insn,
    input  logic              pcpi_ready,
    input  logic              pcpi_wr,
    input  logic              pcpi_wait,
    input  logic [RD_W-1:0]   pcpi_rd,
    output logic [SEG_W-1:0]  rd_seg_out,
    output logic              rd_seg_valid,
    input  logic              rd_seg_ack,
    output logic              busy,
    output logic              err
);

    localparam int NSEG_I = INSN_W / SEG_W;
    localparam int NSEG_R = RD_W / SEG_W;
    localparam int IW     = idx_w(NSEG_I);
    localparam int RW     = idx_w(NSEG_R);
    localparam logic [IW-1:0] LAST_I = IW'(NSEG_I - 1);
    localparam logic [RW-1:0] LAST_R = RW'(NSEG_R - 1);

    if ((INSN_W % SEG_W) != 0) begin : g_bad_insn_w
        $error("INSN_W must be a multiple of SEG_W");
    end
    if ((RD_W % SEG_W) != 0) begin : g_bad_rd_w
        $error("RD_W must be a multiple of SEG_W");
    end

    state_t          r_state;
    state_t          w_next;
    logic            r_sv_q;
    logic            r_seg_ack;
    logic [IW-1:0]   r_idx;
    logic [RW-1:0]   r_ridx;
    logic            w_cap;
    logic            w_cap_last;
    logic            w_rd_adv;
    logic            w_ld_rd;
    logic            w_tmo;
    logic [SEG_W-1:0] w_insn_seg_unused;
    logic [RD_W-1:0]  w_res_q_unused;

    // Strobe edge is only honoured while loading.
    assign w_cap      = seg_valid & ~r_sv_q & (r_state == ST_LOAD);
    assign w_cap_last = w_cap & (r_idx == LAST_I);
    assign w_rd_adv   = rd_seg_ack & (r_state == ST_DRAIN);
    assign w_ld_rd    = (r_state == ST_ISSUE) & pcpi_ready & pcpi_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // A ready in the timeout cycle completes normally.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_LOAD: begin
                if (w_cap_last) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pcpi_ready) begin
                    w_next = pcpi_wr ? ST_DRAIN : ST_LOAD;
                end else if (w_tmo) begin
                    w_next = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (w_rd_adv && (r_ridx == LAST_R)) begin
                    w_next = ST_LOAD;
                end
            end
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sv_q    <= 1'b0;
            r_seg_ack <= 1'b0;
            r_idx     <= '0;
            r_ridx    <= '0;
        end else begin
            r_sv_q    <= seg_valid;
            r_seg_ack <= w_cap;
            if (w_cap) begin
                r_idx <= w_cap_last ? '0 : r_idx + 1'b1;
            end
            if (w_rd_adv) begin
                r_ridx <= (r_ridx == LAST_R) ? '0 : r_ridx + 1'b1;
            end
        end
    end

`ifdef PCPI_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // Counter is held at zero outside ISSUE, so every entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if ((r_state != ST_ISSUE) || pcpi_wait) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo = (r_state == ST_ISSUE) & ~pcpi_wait
                 & (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_tmo && !pcpi_ready) begin
            r_err <= 1'b1;
        end else if (w_cap && (r_idx == '0)) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    logic [1:0] w_tmo_unused;

    assign w_tmo_unused = {pcpi_wait, (TIMEOUT > 0)};
    assign w_tmo        = 1'b0;
    assign err          = 1'b0;
`endif

    pcpi_seg_slicer #(
        .W     (INSN_W),
        .SEG_W (SEG_W),
        .IDX_W (IW)
    ) u_insn (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_en  (w_cap),
        .i_wr_idx (r_idx),
        .i_wr_seg (seg_in),
        .i_ld_en  (1'b0),
        .i_ld_val ('0),
        .i_rd_idx ('0),
        .o_rd_seg (w_insn_seg_unused),
        .o_q      (pcpi_insn)
    );

    pcpi_seg_slicer #(
        .W     (RD_W),
        .SEG_W (SEG_W),
        .IDX_W (RW)
    ) u_result (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_en  (1'b0),
        .i_wr_idx ('0),
        .i_wr_seg ('0),
        .i_ld_en  (w_ld_rd),
        .i_ld_val (pcpi_rd),
        .i_rd_idx (r_ridx),
        .o_rd_seg (rd_seg_out),
        .o_q      (w_res_q_unused)
    );

    assign seg_ack      = r_seg_ack;
    assign pcpi_valid   = (r_state == ST_ISSUE);
    assign rd_seg_valid = (r_state == ST_DRAIN);
    assign busy         = (r_state != ST_LOAD);

endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// Directed bench for pcpi_serial_bridge (SEG_W=4, INSN_W=32, RD_W=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pcpi_serial_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  seg_in;
    logic        seg_valid;
    logic        seg_ack;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic        pcpi_wait;
    logic [31:0] pcpi_rd;
    logic [3:0]  rd_seg_out;
    logic        rd_seg_valid;
    logic        rd_seg_ack;
    logic        busy;
    logic        err;

    int n_err = 0;
    int n_chk = 0;
    int ack_cnt = 0;
    int base;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (seg_ack) ack_cnt++;
    end

    pcpi_serial_bridge #(
        .SEG_W   (4),
        .INSN_W  (32),
        .RD_W    (32),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_in       (seg_in),
        .seg_valid    (seg_valid),
        .seg_ack      (seg_ack),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_ready   (pcpi_ready),
        .pcpi_wr      (pcpi_wr),
        .pcpi_wait    (pcpi_wait),
        .pcpi_rd      (pcpi_rd),
        .rd_seg_out   (rd_seg_out),
        .rd_seg_valid (rd_seg_valid),
        .rd_seg_ack   (rd_seg_ack),
        .busy         (busy),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_seg(input logic [3:0] nib);
        @(negedge clk);
        seg_in    = nib;
        seg_valid = 1'b1;
        @(negedge clk);
        seg_valid = 1'b0;
    endtask

    task automatic send_insn(input logic [31:0] insn);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = insn >> (4 * i);
            send_seg(v[3:0]);
        end
    endtask

    task automatic complete_nowr();
        @(negedge clk);
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b0;
        @(negedge clk);
        pcpi_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        seg_in     = '0;
        seg_valid  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_wait  = 1'b0;
        pcpi_rd    = '0;
        rd_seg_ack = 1'b0;
        #12;
        check("rst_valid", 32'(pcpi_valid), 0);
        check("rst_ack", 32'(seg_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rdv", 32'(rd_seg_valid), 0);
        check("rst_insn", pcpi_insn, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load: B,0,0,0,0,0,2,0 LSB-first.
        base = ack_cnt;
        send_insn(32'h0200000B);
        check("ld_ack8", 32'(seg_ack), 1);
        check("ld_valid", 32'(pcpi_valid), 1);
        check("ld_insn", pcpi_insn, 32'h0200000B);
        @(negedge clk);
        check("ld_ackcnt", 32'(ack_cnt - base), 8);
        check("ld_busy", 32'(busy), 1);

        // Strobe during ISSUE is ignored.
        base = ack_cnt;
        send_seg(4'hF);
        @(negedge clk);
        check("iss_noack", 32'(ack_cnt - base), 0);
        check("iss_insn", pcpi_insn, 32'h0200000B);
        check("iss_hold", 32'(pcpi_valid), 1);

        // Complete with write-back.
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'h12345678;
        @(negedge clk);
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'hDEADBEEF;
        check("wr_valid0", 32'(pcpi_valid), 0);
        check("wr_rdv", 32'(rd_seg_valid), 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), 32'(rd_seg_out), 32'(8 - i));
            if (i == 2) begin
                @(negedge clk);
                check("drain_hold", 32'(rd_seg_out), 32'(8 - i));
            end
            rd_seg_ack = 1'b1;
            @(negedge clk);
            rd_seg_ack = 1'b0;
        end
        check("drain_rdv0", 32'(rd_seg_valid), 0);
        check("drain_busy0", 32'(busy), 0);

        // Readback ack in LOAD does nothing.
        rd_seg_ack = 1'b1;
        @(negedge clk);
        rd_seg_ack = 1'b0;
        @(negedge clk);
        check("ld_rdack_rdv", 32'(rd_seg_valid), 0);
        check("ld_rdack_busy", 32'(busy), 0);

        // Held strobe captures once.
        base = ack_cnt;
        seg_in    = 4'h5;
        seg_valid = 1'b1;
        repeat (10) @(negedge clk);
        seg_valid = 1'b0;
        @(negedge clk);
        check("hold_once", 32'(ack_cnt - base), 1);
        check("hold_busy", 32'(busy), 0);
        for (int i = 1; i < 8; i++) send_seg(4'(i));
        check("hold_insn", pcpi_insn, 32'h76543215);
        check("hold_valid", 32'(pcpi_valid), 1);
`ifdef PCPI_TIMEOUT_EN
        repeat (3) @(negedge clk);
        check("tmo_pre", 32'(pcpi_valid), 1);
        @(negedge clk);
        check("tmo_valid0", 32'(pcpi_valid), 0);
        check("tmo_err", 32'(err), 1);
        check("tmo_busy0", 32'(busy), 0);
        send_seg(4'h3);
        check("tmo_errclr", 32'(err), 0);
        for (int i = 1; i < 8; i++) send_seg(4'h0);
        check("tmo_insn", pcpi_insn, 32'h00000003);
        complete_nowr();
`else
        repeat (20) @(negedge clk);
        check("wait_valid", 32'(pcpi_valid), 1);
        check("wait_err", 32'(err), 0);
        complete_nowr();
`endif
        check("nowr_valid0", 32'(pcpi_valid), 0);
        check("nowr_busy0", 32'(busy), 0);
        check("nowr_rdv0", 32'(rd_seg_valid), 0);

        // Asynchronous reset after the 5th segment.
        for (int i = 1; i <= 5; i++) send_seg(4'(i));
        check("pre_rst_ack", 32'(seg_ack), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(seg_ack), 0);
        check("arst_insn", pcpi_insn, 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_valid", 32'(pcpi_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = ack_cnt;
        send_insn(32'h21FEDCBA);
        check("post_insn", pcpi_insn, 32'h21FEDCBA);
        check("post_valid", 32'(pcpi_valid), 1);
        @(negedge clk);
        check("post_acks", 32'(ack_cnt - base), 8);
        complete_nowr();
        check("post_busy0", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
